// File: rtl/logic_gates_seq.sv
// Clocked six-gate logic demo: synchronised switch operands, debounced op stepping,
// registered result/LED outputs and a one-cycle strobe whenever the result changes.
module logic_gates_seq #(
    parameter int WIDTH           = 1,
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 120000
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] x0,
    input  logic [WIDTH-1:0] x1,
    input  logic             btn_next,
    output logic [2:0]       op,
    output logic [WIDTH-1:0] result,
    output logic [5:0]       leds,
    output logic             changed,
    output logic [1:0]       dbg_state
);
    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE        = 2'd0,
        CHK_PRESS   = 2'd1,
        HELD        = 2'd2,
        CHK_RELEASE = 2'd3
    } state_t;

    logic [SYNC_STAGES-1:0][WIDTH-1:0] r_x0_sync;
    logic [SYNC_STAGES-1:0][WIDTH-1:0] r_x1_sync;
    logic [SYNC_STAGES-1:0]            r_btn_sync;

    state_t          r_state;
    state_t          w_state_nxt;
    logic [CW-1:0]   r_cnt;
    logic [CW-1:0]   w_cnt_nxt;
    logic            w_step;
    logic            r_step;
    logic [2:0]      r_op;
    logic [WIDTH-1:0] r_result;
    logic [5:0]      r_leds;
    logic            r_changed;

    logic [WIDTH-1:0] w_x0;
    logic [WIDTH-1:0] w_x1;
    logic             w_btn;
    logic [WIDTH-1:0] w_result;
    logic [5:0]       w_leds;

    // Each bit gets its own flop chain; no multi-bit coherence is attempted.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_x0_sync  <= '0;
            r_x1_sync  <= '0;
            r_btn_sync <= '0;
        end else begin
            r_x0_sync  <= {r_x0_sync[SYNC_STAGES-2:0], x0};
            r_x1_sync  <= {r_x1_sync[SYNC_STAGES-2:0], x1};
            r_btn_sync <= {r_btn_sync[SYNC_STAGES-2:0], btn_next};
        end
    end

    assign w_x0  = r_x0_sync[SYNC_STAGES-1];
    assign w_x1  = r_x1_sync[SYNC_STAGES-1];
    assign w_btn = r_btn_sync[SYNC_STAGES-1];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_step  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_step  <= w_step;
        end
    end

    // A press is accepted once; the release must also be stable before re-arming.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_step      = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_btn) begin
                    w_cnt_nxt   = '0;
                    w_state_nxt = CHK_PRESS;
                end
            end
            CHK_PRESS: begin
                if (!w_btn) begin
                    w_state_nxt = IDLE;
                end else if (r_cnt == CNT_LAST) begin
                    w_state_nxt = HELD;
                    w_step      = 1'b1;
                end else begin
                    w_cnt_nxt = r_cnt + CW'(1);
                end
            end
            HELD: begin
                if (!w_btn) begin
                    w_cnt_nxt   = '0;
                    w_state_nxt = CHK_RELEASE;
                end
            end
            CHK_RELEASE: begin
                if (w_btn) begin
                    w_state_nxt = HELD;
                end else if (r_cnt == CNT_LAST) begin
                    w_state_nxt = IDLE;
                end else begin
                    w_cnt_nxt = r_cnt + CW'(1);
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_comb begin
        w_result = '0;
        case (r_op)
            3'd0:    w_result = w_x0 & w_x1;
            3'd1:    w_result = w_x0 | w_x1;
            3'd2:    w_result = ~(w_x0 & w_x1);
            3'd3:    w_result = ~(w_x0 | w_x1);
            3'd4:    w_result = w_x0 ^ w_x1;
            3'd5:    w_result = ~(w_x0 ^ w_x1);
            default: w_result = '0;
        endcase
    end

    assign w_leds = {~(w_x0[0] ^ w_x1[0]), w_x0[0] ^ w_x1[0], ~(w_x0[0] | w_x1[0]),
                     ~(w_x0[0] & w_x1[0]), w_x0[0] | w_x1[0], w_x0[0] & w_x1[0]};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_op      <= 3'd0;
            r_result  <= '0;
            r_leds    <= '0;
            r_changed <= 1'b0;
        end else begin
            if (r_step) begin
                r_op <= (r_op == 3'd5) ? 3'd0 : r_op + 3'd1;
            end
            r_result  <= w_result;
            r_leds    <= w_leds;
            r_changed <= (w_result != r_result);
        end
    end

    assign op        = r_op;
    assign result    = r_result;
    assign leds      = r_leds;
    assign changed   = r_changed;
    assign dbg_state = r_state;
endmodule

// File: doc/logic_gates_seq.md
# logic_gates_seq

Parametrised, clocked successor to the two-input logic-gate demo for the IceZUM board. Takes two WIDTH-bit operands from switches, synchronises them, evaluates all six basic gates in parallel, and outputs one selected gate's result. The selection is stepped by a debounced push-button. All outputs are registered so the block drives board LEDs directly. A one-cycle change strobe lets downstream logic, such as a blinker or UART logger, react to result updates.

## Interface
- WIDTH, 1: operand and result width in bits (≥1)
- SYNC_STAGES, 2: flip-flop stages in each input synchroniser (≥2)
- DEBOUNCE_CYCLES, 120000: cycles a button level must be stable before acceptance (10 ms at 12 MHz; ≥2)
- clk  in  1  system clock (12 MHz on board)
- rst_n  in  1  reset, asynchronous and active-low
- x0  in  WIDTH  operand A, asynchronous switch inputs
- x1  in  WIDTH  operand B, asynchronous switch inputs
- btn_next  in  1  raw active-high button; each debounced press advances the operation
- op  out  3  current operation index, 0..5
- result  out  WIDTH  registered result of the selected gate
- leds  out  6  registered all-gates view of bit 0: [0]AND [1]OR [2]NAND [3]NOR [4]XOR [5]XNOR
- changed  out  1  one-cycle strobe when result takes a new value

## Operation
- **Synchroniser.** x0, x1 and btn_next each pass through a SYNC_STAGES flop chain. All chain flops reset to 0. Each bit is synchronised independently; there is no multi-bit coherence guarantee.
- **Operation encoding.** 0 AND, 1 OR, 2 NAND, 3 NOR, 4 XOR, 5 XNOR. Gates operate bitwise on the synchronised operands.
- **Operation stepping.**
  - op advances by 1 on each accepted press and wraps from 5 to 0.
  - Values 6 and 7 never occur.
- **Debounce FSM** (states IDLE, CHK_PRESS, HELD, CHK_RELEASE), with a counter of $clog2(DEBOUNCE_CYCLES+1) bits:
  - IDLE: when synced button = 1, clear the counter and go to CHK_PRESS.
  - CHK_PRESS: while the button stays 1, increment the counter. When the counter reaches DEBOUNCE_CYCLES-1, issue a one-cycle step pulse and go to HELD. If the button drops to 0 before then, return to IDLE with no step.
  - HELD: when the button = 0, clear the counter and go to CHK_RELEASE.
  - CHK_RELEASE: while the button stays 0, increment the counter. When it reaches DEBOUNCE_CYCLES-1, go to IDLE. If the button returns to 1, go back to HELD.
  - Holding the button indefinitely produces exactly one step.
- **Registers.**
  - result and leds are recomputed every cycle from the synchronised operands and the current op.
  - changed = 1 for exactly the cycle in which the registered result value differs from its previous value. The cause can be an operand change or an op change.
  - A leds-only change (bits other than the selected op) does not assert changed.
- **Reset** (asynchronous, any time, including mid-debounce):
  - op = 0, result = 0, leds = 0, changed = 0.
  - FSM goes to IDLE, counter = 0, all synchroniser flops = 0.
  - A press interrupted by reset is discarded.
  - Operation resumes on the first clk edge after rst_n rises.

## Timing
- **Operand path.** An operand edge is visible on result/leds SYNC_STAGES+1 rising edges later, with changed asserted on that same edge.
- **Button path.** A clean press is seen by the FSM SYNC_STAGES edges after the edge. op updates DEBOUNCE_CYCLES+1 edges after the FSM first sees 1. result reflects the new op 1 edge after op updates.
- **First edge after reset.**
  - leds load the gates of the synchronised zeros, giving 6'b101100.
  - result stays 0 because AND(0,0) = 0, so changed stays 0.
- **Simultaneous events.** If an operand change and an op step land on the same edge, result takes the new op applied to the new operands, and changed is asserted once.
- **Minimum press rate.** Presses spaced closer than about 2×DEBOUNCE_CYCLES+2×SYNC_STAGES cycles may be merged or dropped.

## Test plan
Bench uses WIDTH=4, SYNC_STAGES=2, DEBOUNCE_CYCLES=8, and a clk period of 83.33 ns.
1. Reset with x0=0, x1=0, then release rst_n → op=0, result=4'h0, changed=0 throughout; leds=6'b101100 from the first edge.
2. op=0: x0=4'b1100, x1=4'b1010 → 3 edges later result=4'b1000, with changed high for exactly 1 cycle. Then step to each op in turn, expecting:
   - OR: 4'b1110
   - NAND: 4'b0111
   - NOR: 4'b0001
   - XOR: 4'b0110
   - XNOR: 4'b1001
3. Six clean presses (20 cycles high / 20 low) → op sequence 1,2,3,4,5,0. Hold the button for 200 cycles → exactly one increment.
4. Bounce: toggle btn_next every 3 cycles for 30 cycles, then low → op unchanged. Stay high for 5 cycles, then low → no step.
5. Assert rst_n low mid-CHK_PRESS at op=3, release, then press → op goes 0 then 1; no step from the aborted press.
6. Operand change and op step landing on the same edge → single changed pulse; result equals the new op applied to the new operands.
